encrypt_scheduler: RTL and testbench



---
 rtl/encrypt_scheduler.sv | 126 ++++++++++++
 tb/tb_encrypt_scheduler.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/encrypt_scheduler.sv
// Round-robin front end for the combinational encrypter: latches one requester's record
// and the baby key, holds them for SETTLE_CYCLES, then presents the captured result.
module encrypt_scheduler #(
   parameter int N_REQ         = 4,
   parameter int SRC_W         = 2,
   parameter int SETTLE_CYCLES = 2
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [N_REQ-1:0]      req_valid,
   input  logic [80*N_REQ-1:0]   req_data,
   output logic [N_REQ-1:0]      req_ready,
   input  logic [63:0]           master_key,
   input  logic [63:0]           baby_key_in,
   input  logic                  baby_key_load,
   output logic                  key_ack,
   output logic [79:0]           enc_data_in,
   output logic [63:0]           enc_master_key,
   output logic [63:0]           enc_baby_key,
   input  logic [79:0]           enc_data_out,
   input  logic [7:0]            enc_crc,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [79:0]           out_data,
   output logic [7:0]            out_crc,
   output logic [SRC_W-1:0]      out_src,
   output logic [15:0]           rec_count
);

   localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_SETTLE = 2'd1;
   localparam logic [1:0] S_OUT    = 2'd2;

   logic [1:0]       state;
   logic [SRC_W-1:0] rr_ptr;
   logic             key_valid;
   logic [CNT_W-1:0] cnt;
   logic [SRC_W-1:0] win_idx;
   logic             win_any;
   logic [SRC_W-1:0] next_ptr;
   logic             grant;
   logic [79:0]      win_data;

   assign enc_master_key = master_key;

   // Scan from the highest offset down so the requester closest to rr_ptr wins.
   always_comb begin
      logic [SRC_W-1:0] idx;
      idx     = '0;
      win_idx = '0;
      win_any = 1'b0;
      for (int i = N_REQ - 1; i >= 0; i--) begin
         idx = SRC_W'((int'(rr_ptr) + i) % N_REQ);
         if (req_valid[idx]) begin
            win_idx = idx;
            win_any = 1'b1;
         end
      end
   end

   assign next_ptr = (win_idx == SRC_W'(N_REQ - 1)) ? '0 : win_idx + SRC_W'(1);
   assign win_data = req_data[80*win_idx +: 80];

   // Key load takes priority over a grant, and nothing is granted without a valid key.
   assign grant = rst_n && (state == S_IDLE) && !baby_key_load && key_valid && win_any;

   always_comb begin
      req_ready = '0;
      if (grant) req_ready[win_idx] = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state        <= S_IDLE;
         rr_ptr       <= '0;
         key_valid    <= 1'b0;
         cnt          <= '0;
         key_ack      <= 1'b0;
         enc_data_in  <= '0;
         enc_baby_key <= '0;
         out_valid    <= 1'b0;
         out_data     <= '0;
         out_crc      <= '0;
         out_src      <= '0;
         rec_count    <= '0;
      end else begin
         key_ack <= 1'b0;
         case (state)
            S_IDLE: begin
               if (baby_key_load) begin
                  enc_baby_key <= baby_key_in;
                  key_valid    <= 1'b1;
                  key_ack      <= 1'b1;
               end else if (grant) begin
                  enc_data_in <= win_data;
                  out_src     <= win_idx;
                  rr_ptr      <= next_ptr;
                  cnt         <= CNT_W'(SETTLE_CYCLES - 1);
                  state       <= S_SETTLE;
               end
            end
            S_SETTLE: begin
               if (cnt == '0) begin
                  out_data  <= enc_data_out;
                  out_crc   <= enc_crc;
                  out_valid <= 1'b1;
                  state     <= S_OUT;
               end else begin
                  cnt <= cnt - CNT_W'(1);
               end
            end
            S_OUT: begin
               if (out_valid && out_ready) begin
                  out_valid <= 1'b0;
                  if (rec_count != 16'hFFFF) rec_count <= rec_count + 16'd1;
                  state <= S_IDLE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_encrypt_scheduler.sv
// Directed bench for encrypt_scheduler with a stubbed XOR encrypter.
module tb_encrypt_scheduler;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [3:0]    req_valid;
   logic [319:0]  req_data;
   logic [3:0]    req_ready;
   logic [63:0]   master_key;
   logic [63:0]   baby_key_in;
   logic          baby_key_load;
   logic          key_ack;
   logic [79:0]   enc_data_in;
   logic [63:0]   enc_master_key;
   logic [63:0]   enc_baby_key;
   logic [79:0]   enc_data_out;
   logic [7:0]    enc_crc;
   logic          out_valid;
   logic          out_ready;
   logic [79:0]   out_data;
   logic [7:0]    out_crc;
   logic [1:0]    out_src;
   logic [15:0]   rec_count;

   always #5 clk = ~clk;

   assign enc_data_out = enc_data_in ^ {16'h0, enc_baby_key};
   assign enc_crc      = enc_data_in[7:0];

   encrypt_scheduler #(.N_REQ(4), .SRC_W(2), .SETTLE_CYCLES(2)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
      .master_key(master_key), .baby_key_in(baby_key_in), .baby_key_load(baby_key_load),
      .key_ack(key_ack), .enc_data_in(enc_data_in), .enc_master_key(enc_master_key),
      .enc_baby_key(enc_baby_key), .enc_data_out(enc_data_out), .enc_crc(enc_crc),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .out_crc(out_crc), .out_src(out_src), .rec_count(rec_count)
   );

   localparam logic [63:0] KEY1 = 64'h0123_4567_89AB_CDEF;
   localparam logic [63:0] KEY2 = 64'hFEDC_BA98_7654_3210;

   typedef struct {
      logic [3:0] mask;
      int         exp_src;
   } vec_t;

   vec_t        tbl[10];
   logic [79:0] rec[4];
   int          checks = 0;
   int          errors = 0;
   logic [15:0] exp_cnt;

   task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic load_recs();
      for (int i = 0; i < 4; i++) req_data[80*i +: 80] = rec[i];
   endtask

   // Called at a falling edge with the DUT idle; returns at the falling edge after the handshake.
   task automatic run_txn(input logic [3:0] mask, input int exp_src, input logic [15:0] cnt_after);
      int   n;
      logic busy_ok;
      logic [79:0] exp_data;
      exp_data  = rec[exp_src] ^ {16'h0, KEY1};
      req_valid = mask;
      #1;
      check("grant_onehot", {76'h0, req_ready}, {76'h0, 4'b0001 << exp_src});
      n = 0;
      busy_ok = 1'b1;
      while (n < 12 && !out_valid) begin
         @(negedge clk);
         n++;
         if (req_ready != 4'b0000) busy_ok = 1'b0;
      end
      check("latency", 80'(n), 80'd3);
      check("no_grant_busy", {79'h0, busy_ok}, 80'h1);
      check("out_valid", {79'h0, out_valid}, 80'h1);
      check("out_src", {78'h0, out_src}, 80'(exp_src));
      check("out_data", out_data, exp_data);
      check("out_crc", {72'h0, out_crc}, {72'h0, rec[exp_src][7:0]});
      @(negedge clk);
      check("out_valid_drop", {79'h0, out_valid}, 80'h0);
      check("rec_count", {64'h0, rec_count}, {64'h0, cnt_after});
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [79:0] snap_data;
      logic [7:0]  snap_crc;
      logic        ack_seen;
      int          n;

      tbl[0] = '{4'b1111, 1};
      tbl[1] = '{4'b1111, 2};
      tbl[2] = '{4'b1111, 3};
      tbl[3] = '{4'b1111, 0};
      tbl[4] = '{4'b0001, 0};
      tbl[5] = '{4'b1000, 3};
      tbl[6] = '{4'b0110, 1};
      tbl[7] = '{4'b0101, 2};
      tbl[8] = '{4'b0011, 0};
      tbl[9] = '{4'b1001, 3};

      rst_n = 1'b0; req_valid = '0; req_data = '0; master_key = 64'hAAAA_5555_F0F0_0F0F;
      baby_key_in = '0; baby_key_load = 1'b0; out_ready = 1'b1;
      repeat (3) @(negedge clk);
      check("rst_out_valid", {79'h0, out_valid}, 80'h0);
      check("rst_req_ready", {76'h0, req_ready}, 80'h0);
      check("rst_key_ack", {79'h0, key_ack}, 80'h0);
      check("rst_rec_count", {64'h0, rec_count}, 80'h0);
      check("rst_out_data", out_data, 80'h0);
      check("rst_enc_data_in", enc_data_in, 80'h0);
      check("rst_enc_baby_key", {16'h0, enc_baby_key}, 80'h0);
      check("master_key_pass", {16'h0, enc_master_key}, {16'h0, 64'hAAAA_5555_F0F0_0F0F});
      rst_n = 1'b1;

      // No key loaded: requests must be held off.
      req_valid = 4'b0001;
      req_data[79:0] = 80'h1;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         check("nokey_req_ready", {76'h0, req_ready}, 80'h0);
         check("nokey_out_valid", {79'h0, out_valid}, 80'h0);
      end

      // Key load then first record.
      baby_key_load = 1'b1; baby_key_in = KEY1;
      #1;
      check("key_priority", {76'h0, req_ready}, 80'h0);
      @(negedge clk);
      baby_key_load = 1'b0;
      #1;
      check("key_ack_pulse", {79'h0, key_ack}, 80'h1);
      check("enc_baby_key", {16'h0, enc_baby_key}, {16'h0, KEY1});
      check("first_grant", {76'h0, req_ready}, 80'h1);
      @(negedge clk);
      check("key_ack_end", {79'h0, key_ack}, 80'h0);
      check("settle_no_ready", {76'h0, req_ready}, 80'h0);
      check("enc_data_in", enc_data_in, 80'h1);
      check("settle_valid0", {79'h0, out_valid}, 80'h0);
      req_valid = 4'b0000;
      @(negedge clk);
      check("settle_valid1", {79'h0, out_valid}, 80'h0);
      @(negedge clk);
      check("first_out_valid", {79'h0, out_valid}, 80'h1);
      check("first_out_data", out_data, 80'h0000_0123_4567_89AB_CDEE);
      check("first_out_src", {78'h0, out_src}, 80'h0);
      check("first_out_crc", {72'h0, out_crc}, 80'h01);
      @(negedge clk);
      check("first_rec_count", {64'h0, rec_count}, 80'h1);
      exp_cnt = 16'd1;

      // Round-robin table.
      rec[0] = 80'hA0A0_1111_2222_3333_4444;
      rec[1] = 80'hB1B1_5555_6666_7777_8888;
      rec[2] = 80'hC2C2_9999_AAAA_BBBB_CCCC;
      rec[3] = 80'hD3D3_DEAD_BEEF_CAFE_F00D;
      load_recs();
      for (int t = 0; t < 10; t++) begin
         exp_cnt++;
         run_txn(tbl[t].mask, tbl[t].exp_src, exp_cnt);
      end

      // Backpressure: output held, no grants, key load ignored.
      out_ready = 1'b0;
      req_valid = 4'b0001;
      #1;
      check("stall_grant", {76'h0, req_ready}, 80'h1);
      n = 0;
      while (n < 12 && !out_valid) begin
         @(negedge clk);
         n++;
      end
      check("stall_valid", {79'h0, out_valid}, 80'h1);
      snap_data = out_data;
      snap_crc  = out_crc;
      check("stall_data_val", snap_data, rec[0] ^ {16'h0, KEY1});
      ack_seen = 1'b0;
      for (int i = 0; i < 10; i++) begin
         baby_key_load = (i == 2 || i == 3);
         baby_key_in   = KEY2;
         @(negedge clk);
         if (key_ack) ack_seen = 1'b1;
         check("stall_hold_valid", {79'h0, out_valid}, 80'h1);
         check("stall_hold_data", out_data, snap_data);
         check("stall_hold_crc", {72'h0, out_crc}, {72'h0, snap_crc});
         check("stall_no_ready", {76'h0, req_ready}, 80'h0);
      end
      baby_key_load = 1'b0;
      check("stall_no_key_ack", {79'h0, ack_seen}, 80'h0);
      check("stall_key_kept", {16'h0, enc_baby_key}, {16'h0, KEY1});
      out_ready = 1'b1;
      req_valid = 4'b0000;
      @(negedge clk);
      exp_cnt++;
      check("stall_release", {79'h0, out_valid}, 80'h0);
      check("stall_rec_count", {64'h0, rec_count}, {64'h0, exp_cnt});

      // Reset during SETTLE aborts the record and clears the key.
      req_valid = 4'b0010;
      #1;
      check("abort_grant", {76'h0, req_ready}, 80'h2);
      @(negedge clk);
      rst_n = 1'b0;
      req_valid = 4'b0000;
      @(negedge clk);
      check("abort_out_valid", {79'h0, out_valid}, 80'h0);
      check("abort_out_data", out_data, 80'h0);
      check("abort_out_crc", {72'h0, out_crc}, 80'h0);
      check("abort_out_src", {78'h0, out_src}, 80'h0);
      check("abort_rec_count", {64'h0, rec_count}, 80'h0);
      check("abort_enc_data_in", enc_data_in, 80'h0);
      check("abort_enc_baby_key", {16'h0, enc_baby_key}, 80'h0);
      check("abort_req_ready", {76'h0, req_ready}, 80'h0);
      rst_n = 1'b1;
      req_valid = 4'b0001;
      n = 0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         if (req_ready != 4'b0000 || out_valid) n++;
      end
      check("abort_key_cleared", 80'(n), 80'h0);
      req_valid = 4'b0000;

      // Saturation of the record counter.
      baby_key_load = 1'b1; baby_key_in = KEY1;
      @(negedge clk);
      baby_key_load = 1'b0;
      #1;
      check("reload_key_ack", {79'h0, key_ack}, 80'h1);
      force dut.rec_count = 16'hFFFE;
      #1;
      release dut.rec_count;
      run_txn(4'b0001, 0, 16'hFFFF);
      run_txn(4'b0001, 0, 16'hFFFF);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
